// File: rtl/regfile_io.sv
// regfile_io: picoMIPS register file feeding the ALU.
//   Two combinational read ports (with write-through bypass), one write port.
//   Entry 0 reads as zero; reads of IN_REG return the synchronised switches;
//   writes to OUT_REG are also presented on a valid/ack output port, and a
//   write that would overrun an unaccepted output raises stall.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ra1/rd1, ra2/rd2  read address / combinational read data, ports 1 and 2
//   we, wa, wd        write enable, address, data (ALU result)
//   sw_in             asynchronous switch input
//   out_data          output port data
//   out_valid         output port data valid
//   out_ack           consumer accepts out_data
//   stall             core must hold the current instruction
//
// Output port FSM:
//   state | meaning
//   EMPTY | no pending output, out_valid = 0
//   FULL  | out_data pending, out_valid = 1, waiting for out_ack
module regfile_io #(
    parameter int n         = 8,
    parameter int addr_size = 5,
    parameter int IN_REG    = 1,
    parameter int OUT_REG   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [addr_size-1:0] ra1,
    input  logic [addr_size-1:0] ra2,
    output logic [n-1:0]         rd1,
    output logic [n-1:0]         rd2,
    input  logic                 we,
    input  logic [addr_size-1:0] wa,
    input  logic [n-1:0]         wd,
    input  logic [n-1:0]         sw_in,
    output logic [n-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 stall
);

    localparam int DEPTH = 2 ** addr_size;
    localparam logic [addr_size-1:0] IN_ADDR  = addr_size'(IN_REG);
    localparam logic [addr_size-1:0] OUT_ADDR = addr_size'(OUT_REG);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [n-1:0] mem [DEPTH];
    logic [n-1:0] sw_meta;
    logic [n-1:0] sw_sync;
    logic [0:0]   state;
    logic         wr_out;
    logic         wr_ok;

    assign out_valid = (state == FULL);
    assign wr_out    = we && (wa == OUT_ADDR);
    // A write to the output register while the previous value is unaccepted
    // must be held off entirely: no storage update, no bypass, no FSM change.
    assign stall     = wr_out && (state == FULL) && !out_ack;
    assign wr_ok     = we && !stall && (wa != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            out_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (wr_out) begin
                        out_data <= wd;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    // ack together with a new write is a handover, not a stall
                    if (out_ack && wr_out) begin
                        out_data <= wd;
                    end else if (out_ack) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_comb begin
        rd1 = mem[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (ra1 == IN_ADDR) begin
            rd1 = sw_sync;
        end else if (we && !stall && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = mem[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (ra2 == IN_ADDR) begin
            rd2 = sw_sync;
        end else if (we && !stall && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: tb/tb_regfile_io.sv
// Directed bench for regfile_io: reset, write/bypass, zero register,
// input synchroniser latency, output handshake, stall and mid-run reset.
module tb_regfile_io;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ra1, ra2, wa;
    logic [7:0] rd1, rd2, wd, sw_in, out_data;
    logic       we, out_valid, out_ack, stall;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_io dut (
        .clk       (clk),
        .reset     (reset),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .sw_in     (sw_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // advance one rising edge, then settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after changing inputs
    task automatic settle();
        #3;
    endtask

    initial begin
        reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 8'h55;
        ra1 = '0; ra2 = '0; sw_in = 8'h00; out_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0; we = 1'b0;
        ra1 = 5'd3; ra2 = 5'd0;
        settle();
        chk("rst_rd1", rd1, 8'h00);
        chk("rst_rd2", rd2, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_out_data", out_data, 8'h00);

        // write with same-cycle bypass, then from storage
        we = 1'b1; wa = 5'd5; wd = 8'hA3; ra1 = 5'd5;
        settle();
        chk("bypass", rd1, 8'hA3);
        tick();
        we = 1'b0;
        settle();
        chk("stored", rd1, 8'hA3);

        // entry 0 discards writes, including on the bypass path
        we = 1'b1; wa = 5'd0; wd = 8'hFF; ra1 = 5'd0;
        settle();
        chk("zero_bypass", rd1, 8'h00);
        tick();
        we = 1'b0;
        settle();
        chk("zero_stored", rd1, 8'h00);

        // input synchroniser: two edges of latency
        ra2 = 5'd1; sw_in = 8'h7E;
        settle();
        chk("sync_e0", rd2, 8'h00);
        tick();
        chk("sync_e1", rd2, 8'h00);
        tick();
        chk("sync_e2", rd2, 8'h7E);
        we = 1'b1; wa = 5'd1; wd = 8'h11;
        settle();
        chk("in_reg_nobypass", rd2, 8'h7E);
        tick();
        we = 1'b0;
        settle();
        chk("in_reg_nowrite", rd2, 8'h7E);

        // output handshake
        we = 1'b1; wa = 5'd2; wd = 8'h42; ra1 = 5'd2;
        settle();
        chk("empty_nostall", stall, 1'b0);
        tick();
        we = 1'b0;
        settle();
        chk("out_valid_set", out_valid, 1'b1);
        chk("out_data_42", out_data, 8'h42);
        chk("rd1_reg2", rd1, 8'h42);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        settle();
        chk("out_valid_clr", out_valid, 1'b0);
        chk("out_data_hold", out_data, 8'h42);

        // stall while FULL and unacknowledged
        we = 1'b1; wa = 5'd2; wd = 8'h42;
        tick();
        wd = 8'h99;
        settle();
        chk("stall_set", stall, 1'b1);
        chk("stall_nobypass", rd1, 8'h42);
        tick();
        settle();
        chk("stall_held", stall, 1'b1);
        chk("stall_out_data", out_data, 8'h42);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_entry2", rd1, 8'h42);
        out_ack = 1'b1;
        settle();
        chk("ack_unstall", stall, 1'b0);
        chk("ack_bypass", rd1, 8'h99);
        tick();
        we = 1'b0; out_ack = 1'b0;
        settle();
        chk("handover_data", out_data, 8'h99);
        chk("handover_valid", out_valid, 1'b1);
        chk("handover_entry2", rd1, 8'h99);

        // back-to-back writes with ack held high
        out_ack = 1'b1; we = 1'b1; wa = 5'd2; wd = 8'h10;
        tick();
        chk("b2b_data1", out_data, 8'h10);
        chk("b2b_valid1", out_valid, 1'b1);
        wd = 8'h20;
        settle();
        chk("b2b_nostall", stall, 1'b0);
        tick();
        chk("b2b_data2", out_data, 8'h20);
        wd = 8'h42;
        tick();
        we = 1'b0; out_ack = 1'b0;
        settle();
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_data", out_data, 8'h42);

        // reset while FULL overrides concurrent write and ack
        reset = 1'b1; we = 1'b1; wa = 5'd5; wd = 8'h77; out_ack = 1'b1;
        tick();
        reset = 1'b0; we = 1'b0; out_ack = 1'b0;
        ra2 = 5'd1;
        settle();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_sync", rd2, 8'h00);
        for (int i = 2; i < 32; i++) begin
            ra1 = 5'(i);
            #1;
            chk($sformatf("mid_rst_reg%0d", i), rd1, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_io.md
# regfile_io

Register file for the picoMIPS datapath, directly upstream of the ALU. It supplies operands `a`/`b` on read ports 1/2 and captures the ALU `result` on its single write port. Register 0 is hardwired to zero. Register 1 reads a synchronised copy of the external input switches. Writes to register 2 are also presented on an output port under a valid/ack handshake, with a stall request to the core.

## Interface
- `n`, default `DATA_BUS_SIZE` (8): data width, equal to the ALU operand width.
- `addr_size`, default 5: register address width; `2**addr_size` registers.
- `IN_REG`, default 1: address whose reads return the synchronised input port.
- `OUT_REG`, default 2: address whose writes drive the output port.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ra1`  in  addr_size  read address, port 1 (drives ALU `a`).
- `ra2`  in  addr_size  read address, port 2 (drives ALU `b`).
- `rd1`  out  n  read data, port 1, combinational.
- `rd2`  out  n  read data, port 2, combinational.
- `we`  in  1  write enable.
- `wa`  in  addr_size  write address.
- `wd`  in  n  write data (ALU `result`).
- `sw_in`  in  n  asynchronous external input (switches).
- `out_data`  out  n  output port data.
- `out_valid`  out  1  output port data valid.
- `out_ack`  in  1  consumer accepts `out_data`.
- `stall`  out  1  core must hold the current instruction.

## Operation
- Storage: `2**addr_size` × n flops. Entry 0 always reads 0, and writes to it are discarded.
- Write: on a rising edge with `we`=1, `wa`≠0 and `stall`=0, store `wd` in entry `wa`. When `stall`=1, no state change of any kind is caused by the write.
- Read, evaluated in priority order for each port independently:
  - If `ra`=0, return 0.
  - Else if `ra`=`IN_REG`, return `sw_sync`.
  - Else if `we`=1, `wa`=`ra` and `stall`=0, return `wd` (write-through bypass).
  - Otherwise return the stored entry.
- Entry `IN_REG` is writable but never readable. Reads of it always return `sw_sync`.
- Input path: two-flop synchroniser `sw_in` → `sw_meta` → `sw_sync`, updated every cycle.
- Output port state machine, with states EMPTY (`out_valid`=0) and FULL (`out_valid`=1):
  - EMPTY, write to `OUT_REG`: `out_data` ← `wd`, go to FULL.
  - FULL, `out_ack`=1, no write to `OUT_REG`: go to EMPTY. `out_data` holds its last value.
  - FULL, `out_ack`=1, write to `OUT_REG` in the same cycle: `out_data` ← `wd`, stay FULL. This is an accepted write, not a stall.
  - FULL, `out_ack`=0, write to `OUT_REG`: `stall`=1. Write blocked, state unchanged.
- `stall` = `we` & (`wa`==`OUT_REG`) & `out_valid` & ~`out_ack`. Combinational, no registered delay.
- Width: all data is n bits and passed through unmodified. No sign or width conversion is applied.

## Timing
- Reset, in the cycle after `reset` is sampled high:
  - All entries, `sw_meta`, `sw_sync` and `out_data` are 0.
  - `out_valid`=0, so `stall`=0.
  - `reset` overrides any concurrent write or ack.
- Reset asserted while FULL: the pending output is dropped and `out_valid`=0 after the edge.
- Read latency is 0 cycles (combinational). The bypass makes a write visible to a read in the same cycle.
- Write latency: stored at the rising edge and visible from storage in the next cycle.
- Input latency: a change on `sw_in` appears on `rd1`/`rd2` (`ra`=`IN_REG`) exactly 2 edges later.
- `out_valid` rises on the edge that accepts the write. It falls on the first edge where `out_ack`=1 with no new write.
- Simultaneous writes to `OUT_REG` on consecutive cycles with `out_ack` held high: each is accepted, and `out_data` updates every cycle.

## Test plan
- Reset then read: assert `reset` one cycle with `we`=1, `wa`=3, `wd`=8'h55. Then read `ra1`=3, `ra2`=0 → `rd1`=0, `rd2`=0, `out_valid`=0, `stall`=0.
- Write/bypass/zero:
  - `we`=1, `wa`=5, `wd`=8'hA3, `ra1`=5 → `rd1`=8'hA3 in the same cycle, and still 8'hA3 next cycle with `we`=0.
  - `we`=1, `wa`=0, `wd`=8'hFF → subsequent read of 0 returns 0.
- Input sync: `sw_in` goes from 8'h00 to 8'h7E with `ra2`=1 → `rd2`=0 for 2 edges, then 8'h7E. A write of 8'h11 to entry 1 does not change `rd2`.
- Output handshake:
  - Write 8'h42 to reg 2 → next cycle `out_valid`=1, `out_data`=8'h42, `rd1`(`ra1`=2)=8'h42.
  - `out_ack`=1 for one cycle → `out_valid`=0, `out_data` stays 8'h42.
- Stall:
  - FULL with 8'h42 and `out_ack`=0, then write 8'h99 to reg 2 → `stall`=1. `out_data` and entry 2 stay 8'h42, and bypass is disabled, so `rd1`(`ra1`=2)=8'h42.
  - Raise `out_ack` → `stall`=0 and 8'h99 is accepted, so `out_data`=8'h99 and `out_valid` stays 1.
- Reset mid-operation: FULL with 8'h42, then assert `reset` → `out_valid`=0 and `out_data`=0 next cycle, and the register file reads all zero.
